// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: owns the fetch PC, issues credit-limited word requests to instruction memory and
// buffers in-order responses with their PCs for decode; a redirect flushes and squashes in-flight.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [XLEN-1:0]         imem_req_addr,
   input  logic                    imem_resp_valid,
   input  logic [31:0]             imem_resp_data,
   input  logic                    redirect,
   input  logic [XLEN-1:0]         redirect_pc,
   output logic                    fetch_valid,
   input  logic                    fetch_ready,
   output logic [31:0]             fetch_instruction,
   output logic [XLEN-1:0]         fetch_pc,
   output logic [XLEN-1:0]         fetch_pc_plus_four,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int              C_AW      = $clog2(DEPTH);
   localparam int              C_CW      = C_AW + 1;
   localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

   logic [XLEN-1:0] r_fetch_addr;
   logic [XLEN-1:0] r_resp_pc;
   logic [C_CW-1:0] r_outstanding;
   logic [C_CW-1:0] r_discard;
   logic [C_CW-1:0] r_count;
   logic [C_AW-1:0] r_wptr;
   logic [C_AW-1:0] r_rptr;
   logic [31:0]     r_instr [DEPTH];
   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [XLEN-1:0] r_pc4   [DEPTH];

   logic [C_CW:0]   w_inflight;
   logic            w_credit;
   logic            w_req_fire;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_redirect_pc;

   // Outstanding plus buffered never exceeds DEPTH, so every response is guaranteed a slot.
   assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_credit       = w_inflight < (C_CW + 1)'(DEPTH);
   assign imem_req_valid = reset && !redirect && w_credit;
   assign imem_req_addr  = r_fetch_addr;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_push         = imem_resp_valid && (r_discard == '0);
   assign w_pop          = (r_count != '0) && fetch_ready;
   assign w_redirect_pc  = redirect_pc & ~XLEN'(3);

   assign fetch_valid        = (r_count != '0);
   assign occupancy          = r_count;
   assign fetch_instruction  = r_instr[r_rptr];
   assign fetch_pc           = r_pc[r_rptr];
   assign fetch_pc_plus_four = r_pc4[r_rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_addr  <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= '0;
            r_pc[i]    <= '0;
            r_pc4[i]   <= '0;
         end
      end else if (redirect) begin
         // Everything still in flight after this cycle belongs to the old path.
         r_count       <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_outstanding <= r_outstanding - C_CW'(imem_resp_valid);
         r_discard     <= r_outstanding - C_CW'(imem_resp_valid);
         r_fetch_addr  <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
      end else begin
         if (w_req_fire) begin
            r_fetch_addr <= r_fetch_addr + C_PC_STEP;
         end
         r_outstanding <= r_outstanding + C_CW'(w_req_fire) - C_CW'(imem_resp_valid);
         if (imem_resp_valid && (r_discard != '0)) begin
            r_discard <= r_discard - C_CW'(1);
         end
         if (w_push) begin
            r_instr[r_wptr] <= imem_resp_data;
            r_pc[r_wptr]    <= r_resp_pc;
            r_pc4[r_wptr]   <= r_resp_pc + C_PC_STEP;
            r_wptr          <= r_wptr + C_AW'(1);
            r_resp_pc       <= r_resp_pc + C_PC_STEP;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + C_AW'(1);
         end
         r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed bench with an in-order memory model and a PC scoreboard.
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_resp_valid;
   logic [31:0]       imem_resp_data;
   logic              redirect;
   logic [XLEN-1:0]   redirect_pc;
   logic              fetch_valid;
   logic              fetch_ready;
   logic [31:0]       fetch_instruction;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   fetch_pc_plus_four;
   logic [2:0]        occupancy;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk                (clk),
      .reset              (reset),
      .imem_req_valid     (imem_req_valid),
      .imem_req_ready     (imem_req_ready),
      .imem_req_addr      (imem_req_addr),
      .imem_resp_valid    (imem_resp_valid),
      .imem_resp_data     (imem_resp_data),
      .redirect           (redirect),
      .redirect_pc        (redirect_pc),
      .fetch_valid        (fetch_valid),
      .fetch_ready        (fetch_ready),
      .fetch_instruction  (fetch_instruction),
      .fetch_pc           (fetch_pc),
      .fetch_pc_plus_four (fetch_pc_plus_four),
      .occupancy          (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t       mem_q[$];
   logic [31:0] sb_q[$];
   logic [31:0] exp_addr;
   int unsigned cyc;
   int unsigned mem_lat;
   int          n_pass;
   int          n_total;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int k = 0;
      while (!fetch_valid && k < budget) begin
         step();
         k++;
      end
      chk(tag, fetch_valid, 1);
   endtask

   // Memory: in-order responses, mem_lat cycles after acceptance, at most one per cycle.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      cyc             = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         imem_resp_valid = 1'b0;
         if (reset && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
         end
      end
   end

   // Handshakes are observed mid-cycle; they complete at the following rising edge.
   initial begin
      logic [31:0] p;
      logic [31:0] p4;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mem_q.delete();
            sb_q.delete();
            exp_addr = '0;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            end
            if (redirect) begin
               chk("redir_no_req", imem_req_valid, 0);
               sb_q.delete();
               exp_addr = redirect_pc & 32'hFFFFFFFC;
            end else begin
               if (fetch_valid && fetch_ready) begin
                  chk("sb_nonempty", sb_q.size() != 0, 1);
                  if (sb_q.size() != 0) begin
                     p  = sb_q.pop_front();
                     p4 = p + 32'd4;
                     chk("pop_pc", fetch_pc, p);
                     chk("pop_instr", fetch_instruction, mem_word(p));
                     chk("pop_pc4", fetch_pc_plus_four, p4);
                  end
               end
               if (imem_req_valid && imem_req_ready) begin
                  chk("req_addr", imem_req_addr, exp_addr);
                  sb_q.push_back(exp_addr);
                  exp_addr = exp_addr + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      logic        stall;
      logic [31:0] held;
      int          k;
      n_pass         = 0;
      n_total        = 0;
      reset          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      fetch_ready    = 1'b1;
      mem_lat        = 1;
      exp_addr       = '0;

      step(3);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_instr", fetch_instruction, 0);
      chk("rst_pc", fetch_pc, 0);
      chk("rst_pc4", fetch_pc_plus_four, 0);
      chk("rst_req_addr", imem_req_addr, 0);

      // First accept at the next edge; data visible two cycles after it.
      reset = 1'b1;
      #1;
      chk("t1_req_valid", imem_req_valid, 1);
      step();
      chk("t1_lat1", fetch_valid, 0);
      step();
      chk("t1_lat2", fetch_valid, 1);
      chk("t1_first_pc", fetch_pc, 0);
      chk("t1_first_instr", fetch_instruction, mem_word(32'h0));
      step(10);

      // Decode stalled: credit must close when the queue plus in-flight reaches DEPTH.
      fetch_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("t2_credit", imem_req_valid, sb_q.size() < DEPTH);
      end
      chk("t2_occ_full", occupancy, DEPTH);
      chk("t2_req_blocked", imem_req_valid, 0);
      fetch_ready = 1'b1;
      step(12);

      mem_lat = 3;
      step(8);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      chk("t3_flush_occ", occupancy, 0);
      wait_valid("t3_wait", 40);
      chk("t3_pc", fetch_pc, 32'h100);
      chk("t3_pc4", fetch_pc_plus_four, 32'h104);
      chk("t3_instr", fetch_instruction, mem_word(32'h100));
      step(6);

      // Redirect coinciding with a response and a decode handshake.
      mem_lat = 1;
      step(6);
      k = 0;
      while (!(imem_resp_valid && fetch_valid) && k < 40) begin
         step();
         k++;
      end
      chk("t4_align", imem_resp_valid && fetch_valid, 1);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      chk("t4_flush_occ", occupancy, 0);
      chk("t4_flush_valid", fetch_valid, 0);
      wait_valid("t4_wait", 40);
      chk("t4_pc", fetch_pc, 32'h200);
      step(4);

      for (int i = 0; i < 60; i++) begin
         imem_req_ready = 1'($urandom_range(1, 0));
         fetch_ready    = 1'($urandom_range(1, 0));
         #1;
         stall = imem_req_valid && !imem_req_ready;
         held  = imem_req_addr;
         step();
         if (stall) begin
            chk("t5_valid_held", imem_req_valid, 1);
            chk("t5_addr_held", imem_req_addr, held);
         end
      end
      imem_req_ready = 1'b1;
      fetch_ready    = 1'b1;
      step(10);

      // Address wrap at the top of the address space, then an asynchronous reset.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFFFFF8;
      fetch_ready = 1'b0;
      step();
      redirect = 1'b0;
      step(8);
      chk("t6_occ_full", occupancy, 4);
      chk("t6_pc0", fetch_pc, 32'hFFFFFFF8);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      chk("t6_pc1", fetch_pc, 32'hFFFFFFFC);
      chk("t6_pc1_p4", fetch_pc_plus_four, 32'h0);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      chk("t6_pc2", fetch_pc, 32'h0);
      chk("t6_pc2_p4", fetch_pc_plus_four, 32'h4);
      step();
      chk("t6_occ3", occupancy, 3);
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", fetch_valid, 0);
      chk("t6_rst_occ", occupancy, 0);
      chk("t6_rst_req", imem_req_valid, 0);
      step(2);
      reset       = 1'b1;
      fetch_ready = 1'b1;
      step();
      wait_valid("t6_restart_wait", 20);
      chk("t6_restart_pc", fetch_pc, 32'h0);
      step(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
